// File: rtl/minterm_sweeper_if.sv
// +--------------------------------------------------------------------------+
// | minterm_sweeper_if : control/observation bundle for minterm_sweeper      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface minterm_sweeper_if #(
    parameter int N_IN = 4
);
    logic                   tt_we;
    logic [(1<<N_IN)-1:0]   tt_din;
    logic [N_IN-1:0]        eval_in;
    logic                   f_comb;
    logic                   start;
    logic                   gray;
    logic                   abort;
    logic                   busy;
    logic [N_IN-1:0]        vec;
    logic                   f;
    logic                   vec_vld;
    logic [N_IN:0]          ones_cnt;
    logic                   done;

    modport master (
        output tt_we, tt_din, eval_in, start, gray, abort,
        input  f_comb, busy, vec, f, vec_vld, ones_cnt, done
    );

    modport slave (
        input  tt_we, tt_din, eval_in, start, gray, abort,
        output f_comb, busy, vec, f, vec_vld, ones_cnt, done
    );
endinterface

`default_nettype wire

// File: rtl/minterm_sweeper.sv
// +--------------------------------------------------------------------------+
// | minterm_sweeper : loadable truth table with exhaustive binary/Gray sweep |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module minterm_sweeper #(
    parameter int N_IN     = 4,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    minterm_sweeper_if.slave  bus
);
    localparam int DEPTH = 1 << N_IN;
    localparam int HW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  tt_q, tt_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              gray_q, gray_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              f_q, f_d;
    logic              vld_q, vld_d;
    logic [N_IN:0]     ones_q, ones_d;

    logic [DEPTH-1:0]  tt_eff;
    logic [N_IN-1:0]   idx_inc;
    logic [N_IN-1:0]   vec_inc;

    // A write in the same cycle as start must already be visible to vector 0.
    assign tt_eff  = bus.tt_we ? bus.tt_din : tt_q;
    assign idx_inc = idx_q + N_IN'(1);
    assign vec_inc = gray_q ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        gray_d  = gray_q;
        vec_d   = vec_q;
        f_d     = f_q;
        vld_d   = 1'b0;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE: begin
                if (bus.tt_we) begin
                    tt_d = bus.tt_din;
                end
                if (bus.start) begin
                    state_d = S_RUN;
                    gray_d  = bus.gray;
                    idx_d   = '0;
                    hold_d  = '0;
                    vec_d   = '0;
                    f_d     = tt_eff[0];
                    vld_d   = 1'b1;
                    ones_d  = (N_IN+1)'(tt_eff[0]);
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_inc;
                        hold_d = '0;
                        vec_d  = vec_inc;
                        f_d    = tt_q[vec_inc];
                        vld_d  = 1'b1;
                        ones_d = ones_q + (N_IN+1)'(tt_q[vec_inc]);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tt_q    <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            gray_q  <= 1'b0;
            vec_q   <= '0;
            f_q     <= 1'b0;
            vld_q   <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gray_q  <= gray_d;
            vec_q   <= vec_d;
            f_q     <= f_d;
            vld_q   <= vld_d;
            ones_q  <= ones_d;
        end
    end

    assign bus.f_comb   = tt_q[bus.eval_in];
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.vec      = vec_q;
    assign bus.f        = f_q;
    assign bus.vec_vld  = vld_q;
    assign bus.ones_cnt = ones_q;
endmodule

`default_nettype wire

// File: tb/tb_minterm_sweeper.sv
// +--------------------------------------------------------------------------+
// | tb_minterm_sweeper : directed self-checking bench for minterm_sweeper    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_minterm_sweeper;
    localparam logic [15:0] TT_A = 16'h87B6;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   gray_seq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    minterm_sweeper_if #(.N_IN(4)) b1 ();
    minterm_sweeper_if #(.N_IN(4)) b3 ();

    minterm_sweeper #(.N_IN(4), .HOLD_CYC(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    minterm_sweeper #(.N_IN(4), .HOLD_CYC(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sweep on u1; optionally loads the table with start and
    // injects an ignored write+start mid-sweep.
    task automatic sweep1(input logic g, input logic [15:0] tbl, input logic load,
                          input logic inject, input int exp_ones);
        int ones;
        int v;
        int prev;
        ones = 0;
        prev = 0;
        b1.start = 1'b1;
        b1.gray  = g;
        if (load) begin
            b1.tt_we  = 1'b1;
            b1.tt_din = tbl;
        end
        tick();
        b1.start = 1'b0;
        b1.gray  = 1'b0;
        b1.tt_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            v = g ? gray_seq[k] : k;
            ones += int'(tbl[v]);
            check_eq("vec", 32'(b1.vec), v);
            check_eq("f", 32'(b1.f), 32'(tbl[v]));
            check_eq("vec_vld", 32'(b1.vec_vld), 1);
            check_eq("busy", 32'(b1.busy), 1);
            check_eq("ones_run", 32'(b1.ones_cnt), ones);
            if (g && k > 0) begin
                check_eq("gray_adj", $countones(b1.vec ^ prev[3:0]), 1);
            end
            prev = int'(b1.vec);
            if (inject && k == 3) begin
                b1.tt_we  = 1'b1;
                b1.tt_din = 16'h0000;
                b1.start  = 1'b1;
            end
            tick();
            b1.tt_we = 1'b0;
            b1.start = 1'b0;
        end
        check_eq("done", 32'(b1.done), 1);
        check_eq("busy_at_done", 32'(b1.busy), 0);
        check_eq("vld_at_done", 32'(b1.vec_vld), 0);
        check_eq("ones_final", 32'(b1.ones_cnt), exp_ones);
        tick();
        check_eq("done_pulse", 32'(b1.done), 0);
        check_eq("ones_hold", 32'(b1.ones_cnt), exp_ones);
        check_eq("vec_hold", 32'(b1.vec), g ? 8 : 15);
    endtask

    initial begin
        int saw;
        int acc;
        int npulse;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        {b1.tt_we, b1.start, b1.gray, b1.abort} = '0;
        {b3.tt_we, b3.start, b3.gray, b3.abort} = '0;
        b1.tt_din = '0; b1.eval_in = 4'd5;
        b3.tt_din = '0; b3.eval_in = 4'd5;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check_eq("rst_vec", 32'(b1.vec), 0);
        check_eq("rst_f", 32'(b1.f), 0);
        check_eq("rst_vld", 32'(b1.vec_vld), 0);
        check_eq("rst_ones", 32'(b1.ones_cnt), 0);
        check_eq("rst_done", 32'(b1.done), 0);
        check_eq("rst_busy", 32'(b1.busy), 0);
        check_eq("rst_fcomb", 32'(b1.f_comb), 0);

        b1.tt_we = 1'b1; b1.tt_din = TT_A;
        tick();
        b1.tt_we = 1'b0;
        check_eq("fcomb5", 32'(b1.f_comb), 1);
        b1.eval_in = 4'd3;
        #1 check_eq("fcomb3", 32'(b1.f_comb), 0);

        // T1 / T2
        sweep1(1'b0, TT_A, 1'b0, 1'b0, 9);
        sweep1(1'b1, TT_A, 1'b0, 1'b0, 9);

        // abort in IDLE must do nothing
        b1.abort = 1'b1;
        tick();
        b1.abort = 1'b0;
        check_eq("idle_abort_busy", 32'(b1.busy), 0);
        check_eq("idle_abort_ones", 32'(b1.ones_cnt), 9);

        // T3: abort while vec=4
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("t3_vec4", 32'(b1.vec), 4);
        b1.abort = 1'b1;
        tick();
        b1.abort = 1'b0;
        check_eq("t3_busy", 32'(b1.busy), 0);
        check_eq("t3_vld", 32'(b1.vec_vld), 0);
        check_eq("t3_ones", 32'(b1.ones_cnt), 3);
        saw = 0;
        for (int k = 0; k < 20; k++) begin
            if (b1.done) saw = 1;
            tick();
        end
        check_eq("t3_no_done", saw, 0);
        check_eq("t3_ones_keep", 32'(b1.ones_cnt), 3);

        // T4: write+start together, ignored write+start during the sweep
        sweep1(1'b0, 16'hFFFF, 1'b1, 1'b1, 16);
        b1.eval_in = 4'd9;
        #1 check_eq("t4_tt_kept", 32'(b1.f_comb), 1);

        // T5: reset at vec=7
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check_eq("t5_vec7", 32'(b1.vec), 7);
        rst_n = 1'b0;
        tick();
        check_eq("t5_vec", 32'(b1.vec), 0);
        check_eq("t5_f", 32'(b1.f), 0);
        check_eq("t5_vld", 32'(b1.vec_vld), 0);
        check_eq("t5_ones", 32'(b1.ones_cnt), 0);
        check_eq("t5_busy", 32'(b1.busy), 0);
        check_eq("t5_done", 32'(b1.done), 0);
        acc = 0;
        for (int e = 0; e < 16; e++) begin
            b1.eval_in = 4'(e);
            #1 acc = acc | int'(b1.f_comb);
        end
        check_eq("t5_tt_clear", acc, 0);
        rst_n = 1'b1;
        tick();

        // T6: HOLD_CYC=3
        b3.tt_we = 1'b1; b3.tt_din = TT_A;
        tick();
        b3.tt_we = 1'b0;
        check_eq("t6_fcomb_idle", 32'(b3.f_comb), 1);
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
        npulse = 0;
        for (int k = 0; k < 16; k++) begin
            for (int h = 0; h < 3; h++) begin
                check_eq("t6_vec", 32'(b3.vec), k);
                check_eq("t6_vld", 32'(b3.vec_vld), (h == 0) ? 1 : 0);
                check_eq("t6_busy", 32'(b3.busy), 1);
                if (b3.vec_vld) npulse++;
                if (k == 8 && h == 1) check_eq("t6_fcomb_run", 32'(b3.f_comb), 1);
                tick();
            end
        end
        check_eq("t6_done", 32'(b3.done), 1);
        check_eq("t6_fcomb_done", 32'(b3.f_comb), 1);
        check_eq("t6_pulses", npulse, 16);
        check_eq("t6_ones", 32'(b3.ones_cnt), 9);
        tick();
        check_eq("t6_done_pulse", 32'(b3.done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
